gemm_job_sequencer: RTL and testbench
=====================================

Name: gemm_job_sequencer

Overview:
- Upstream controller for the GEMM systolic array.
- Accepts one job at a time: a weight matrix plus a row count, then activation rows over a valid/ready handshake into an internal row buffer.
- Once the buffer holds every row, drives the GEMM command sequence: write weights, stream rows back-to-back, then stream zeros until all result rows return.
- Registers each GEMM result row onto its own output port with a last-row flag.

Parameters:
- SA_SIZE, 2, systolic array dimension (rows = columns).
- WEIGHT_ACTIVATION_SIZE, 8, bit width of weights, activations and results.
- MAX_ROWS, 4, maximum activation rows per job; depth of the row buffer.
- DRAIN_TIMEOUT, 64, drain-phase cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- job_start  in  1  start pulse; sampled only in IDLE.
- job_num_rows  in  $clog2(MAX_ROWS+1)  number of activation rows in the job.
- job_weights  in  [SA_SIZE][SA_SIZE] x WAS  weight matrix; captured on accepted job_start.
- job_busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse at job completion.
- job_error  out  1  one-cycle pulse on timeout (optional feature only; tied 0 otherwise).
- act_valid  in  1  activation row valid.
- act_ready  out  1  sequencer can accept a row.
- act_data  in  [SA_SIZE] x WAS  activation row.
- gemm_weight_inputs  out  [SA_SIZE][SA_SIZE] x WAS  to GEMM weight_inputs.
- gemm_activation_inputs  out  [SA_SIZE] x WAS  to GEMM activation_inputs.
- gemm_cmd  out  command_t  to GEMM cmd.
- gemm_output_valid  in  1  from GEMM output_valid.
- gemm_activation_outputs  in  [SA_SIZE] x WAS  from GEMM activation_outputs.
- res_valid  out  1  result row valid; no backpressure.
- res_data  out  [SA_SIZE] x WAS  result row.
- res_last  out  1  marks the final result row of the job.

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. While resetn is low:
  - state goes to IDLE;
  - job_busy, job_done, job_error, act_ready, res_valid and res_last are 0;
  - res_data, gemm_activation_inputs and the captured weights are 0;
  - gemm_cmd is CMD_NONE;
  - all counters are 0.
- Reset mid-job aborts the job. Buffer contents are discarded and no done pulse is issued.
- IDLE:
  - gemm_cmd = CMD_NONE.
  - On job_start with job_num_rows in 1..MAX_ROWS: capture weights and row count, go to FILL.
  - On job_start with job_num_rows == 0: pulse job_done next cycle, stay IDLE, issue no GEMM commands.
  - On job_start with job_num_rows > MAX_ROWS: clamp the count to MAX_ROWS.
- FILL:
  - act_ready = 1.
  - Each act_valid && act_ready handshake writes act_data to buffer[wr_idx] and increments wr_idx.
  - When the write that fills the final row occurs, act_ready drops the next cycle and state goes to LOAD_W.
  - act_valid is ignored in every other state.
- LOAD_W: gemm_cmd = CMD_WRITE_WEIGHTS for exactly one cycle, with gemm_weight_inputs = captured weights. Next state is STREAM.
- STREAM:
  - gemm_cmd = CMD_STREAM; gemm_activation_inputs = buffer[rd_idx]; rd_idx increments each cycle.
  - After row count-1 is presented, go to DRAIN.
  - No bubbles are inserted between rows.
- DRAIN: gemm_cmd = CMD_STREAM with gemm_activation_inputs = 0 until out_cnt == row count, then go to DONE.
- DONE:
  - gemm_cmd = CMD_NONE.
  - job_done = 1 for one cycle; next state is IDLE.
  - job_busy stays high during DONE.
- Output capture:
  - In STREAM or DRAIN, any cycle with gemm_output_valid and out_cnt < row count registers gemm_activation_outputs into res_data.
  - That capture sets res_valid = 1 the next cycle and increments out_cnt.
  - res_last = 1 on the row for which out_cnt becomes the row count.
  - Further gemm_output_valid pulses beyond the row count are ignored.
- Latency: result rows appear one cycle after gemm_output_valid.
- gemm_weight_inputs holds the captured weights from LOAD_W until the next accepted job.
- Arithmetic: no arithmetic beyond counters. Counters are sized $clog2(MAX_ROWS+1) and never wrap within a job.
- A job_start asserted while busy is ignored.

Optional Feature:
- Macro: GEMM_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in DRAIN and clears on entry.
  - If it reaches DRAIN_TIMEOUT before out_cnt equals the row count, job_error pulses one cycle and state returns to IDLE with gemm_cmd = CMD_NONE.
  - No job_done pulse is issued for that job.
- Undefined: DRAIN waits indefinitely and job_error is constant 0.

Test Plan:
- SA_SIZE=2, weights [[1,2],[3,1]], 2 rows [1,2],[5,6] -> res rows [7,4] then [23,16]; res_last on the second row; job_done one cycle after the last result; exactly one CMD_WRITE_WEIGHTS cycle.
- Same job with act_valid gapped (valid every third cycle) -> GEMM sees two consecutive CMD_STREAM rows with no bubble; results identical to the first test.
- job_num_rows=0 -> job_done pulses next cycle; gemm_cmd stays CMD_NONE; no res_valid.
- job_start asserted during STREAM -> ignored; the current job completes with unchanged results; job_busy stays high until DONE.
- resetn low for one cycle during DRAIN -> all outputs return to reset values; a new job [[1,0],[0,1]] with row [9,4] then yields [9,4].
- With GEMM_SEQ_TIMEOUT_EN and a GEMM stub that never asserts output_valid, DRAIN_TIMEOUT=64 -> job_error pulses 64 cycles after DRAIN entry; no job_done; state returns to IDLE.

Source files
------------

// File: rtl/gemm_job_sequencer_if.sv
// gemm_job_sequencer_if: GEMM command encoding plus the job, activation, GEMM and result bundle of the sequencer.
package gemm_job_sequencer_pkg;
  typedef enum logic [1:0] {CMD_NONE, CMD_WRITE_WEIGHTS, CMD_STREAM} command_t;
endpackage

interface gemm_job_sequencer_if #(
  parameter int SA_SIZE = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int MAX_ROWS = 4
);
  import gemm_job_sequencer_pkg::*;
  localparam int CW = $clog2(MAX_ROWS + 1);
  logic job_start;
  logic [CW-1:0] job_num_rows;
  logic [SA_SIZE-1:0][SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] job_weights;
  logic job_busy;
  logic job_done;
  logic job_error;
  logic act_valid;
  logic act_ready;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] act_data;
  logic [SA_SIZE-1:0][SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] gemm_weight_inputs;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] gemm_activation_inputs;
  command_t gemm_cmd;
  logic gemm_output_valid;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] gemm_activation_outputs;
  logic res_valid;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] res_data;
  logic res_last;
  modport master (
    output job_start, job_num_rows, job_weights, act_valid, act_data,
           gemm_output_valid, gemm_activation_outputs,
    input  job_busy, job_done, job_error, act_ready, gemm_weight_inputs,
           gemm_activation_inputs, gemm_cmd, res_valid, res_data, res_last
  );
  modport slave (
    input  job_start, job_num_rows, job_weights, act_valid, act_data,
           gemm_output_valid, gemm_activation_outputs,
    output job_busy, job_done, job_error, act_ready, gemm_weight_inputs,
           gemm_activation_inputs, gemm_cmd, res_valid, res_data, res_last
  );
endinterface

// File: rtl/gemm_job_sequencer.sv
// gemm_job_sequencer: buffers one job of activation rows, then drives GEMM weight load, row stream and drain.
// Optional drain watchdog raising job_error: define GEMM_SEQ_TIMEOUT_EN.
module gemm_job_sequencer
  import gemm_job_sequencer_pkg::*;
#(
  parameter int SA_SIZE = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int MAX_ROWS = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input logic clk,
  input logic resetn,
  gemm_job_sequencer_if.slave bus
);
  localparam int WAS = WEIGHT_ACTIVATION_SIZE;
  localparam int CW = $clog2(MAX_ROWS + 1);
  localparam int AW = MAX_ROWS > 1 ? $clog2(MAX_ROWS) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ROWS);
  typedef logic [SA_SIZE-1:0][WAS-1:0] row_t;
  typedef enum logic [2:0] {IDLE, FILL, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t state_q;
  logic [CW-1:0] rows_q, wr_idx_q, rd_idx_q, out_cnt_q;
  logic [SA_SIZE-1:0][SA_SIZE-1:0][WAS-1:0] weights_q;
  row_t row_buf_q [MAX_ROWS];
  row_t act_in_q, res_data_q;
  command_t cmd_q;
  logic busy_q, done_q, ready_q, res_valid_q, res_last_q;
  logic act_hs, cap;

`ifdef GEMM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  logic [TW-1:0] drain_cnt_q;
  logic error_q;
  assign bus.job_error = error_q;
`else
  localparam int unused_timeout = DRAIN_TIMEOUT;
  assign bus.job_error = 1'b0;
`endif

  assign act_hs = ready_q && bus.act_valid;
  // Results beyond the job's row count (e.g. from drained zero rows) are dropped.
  assign cap = (state_q == STREAM || state_q == DRAIN) && bus.gemm_output_valid && out_cnt_q < rows_q;

  assign bus.job_busy = busy_q;
  assign bus.job_done = done_q;
  assign bus.act_ready = ready_q;
  assign bus.gemm_weight_inputs = weights_q;
  assign bus.gemm_activation_inputs = act_in_q;
  assign bus.gemm_cmd = cmd_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_last = res_last_q;

  always_ff @(posedge clk)
    if (act_hs) row_buf_q[wr_idx_q[AW-1:0]] <= bus.act_data;

  // Outputs are registered, so each state's output values are loaded on the transition into it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rows_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      out_cnt_q <= '0;
      weights_q <= '0;
      act_in_q <= '0;
      res_data_q <= '0;
      cmd_q <= CMD_NONE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q <= 1'b0;
`ifdef GEMM_SEQ_TIMEOUT_EN
      drain_cnt_q <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef GEMM_SEQ_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      res_valid_q <= cap;
      res_last_q <= cap && (out_cnt_q + ONE == rows_q);
      if (cap) begin
        res_data_q <= bus.gemm_activation_outputs;
        out_cnt_q <= out_cnt_q + ONE;
      end
      case (state_q)
        IDLE: if (bus.job_start) begin
          if (bus.job_num_rows == '0) done_q <= 1'b1;
          else begin
            rows_q <= bus.job_num_rows > MAX_CNT ? MAX_CNT : bus.job_num_rows;
            weights_q <= bus.job_weights;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            out_cnt_q <= '0;
            busy_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: if (act_hs) begin
          wr_idx_q <= wr_idx_q + ONE;
          if (wr_idx_q + ONE == rows_q) begin
            ready_q <= 1'b0;
            cmd_q <= CMD_WRITE_WEIGHTS;
            state_q <= LOAD_W;
          end
        end
        LOAD_W: begin
          cmd_q <= CMD_STREAM;
          act_in_q <= row_buf_q[0];
          rd_idx_q <= ONE;
          state_q <= STREAM;
        end
        STREAM: if (rd_idx_q == rows_q) begin
          act_in_q <= '0;
          state_q <= DRAIN;
`ifdef GEMM_SEQ_TIMEOUT_EN
          drain_cnt_q <= '0;
`endif
        end else begin
          act_in_q <= row_buf_q[rd_idx_q[AW-1:0]];
          rd_idx_q <= rd_idx_q + ONE;
        end
        DRAIN: begin
          if (out_cnt_q == rows_q) begin
            cmd_q <= CMD_NONE;
            done_q <= 1'b1;
            state_q <= DONE;
          end
`ifdef GEMM_SEQ_TIMEOUT_EN
          else if (drain_cnt_q == TW'(DRAIN_TIMEOUT - 1)) begin
            cmd_q <= CMD_NONE;
            error_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= IDLE;
          end else drain_cnt_q <= drain_cnt_q + T_ONE;
`endif
        end
        DONE: begin
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_job_sequencer.sv
// tb_gemm_job_sequencer: directed jobs against a latency-3 GEMM stub, results checked through an expectation queue.
module tb_gemm_job_sequencer;
  import gemm_job_sequencer_pkg::*;
  typedef logic [1:0][7:0] row_t;
  typedef logic [1:0][1:0][7:0] mat_t;
  typedef struct packed { row_t d; logic last; } exp_t;
  localparam int L = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic stub_mute = 1'b0;
  int errors = 0, checks = 0;
  int done_cnt = 0, ww_cnt = 0, err_cnt = 0, cmd_cycles = 0, sidx = 0;
  int t, k, ww0, dn0, c0, busy_low;
  logic prev_ww = 1'b0, done_due = 1'b0;
  exp_t exp_q[$];
  row_t slog [2];
  mat_t w1, wid, sw;
  logic [L-1:0] vpipe;
  logic [L-1:0][1:0][7:0] dpipe;

  gemm_job_sequencer_if #(.SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .MAX_ROWS(4)) bus ();
  gemm_job_sequencer #(.SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .MAX_ROWS(4), .DRAIN_TIMEOUT(64)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  function automatic row_t rw(input int a, input int b);
    return {b[7:0], a[7:0]};
  endfunction

  function automatic mat_t mt(input row_t r0, input row_t r1);
    return {r1, r0};
  endfunction

  function automatic row_t mac(input row_t a, input mat_t w);
    row_t y;
    for (int c = 0; c < 2; c++) begin
      y[c] = '0;
      for (int r = 0; r < 2; r++) y[c] = y[c] + a[r] * w[r][c];
    end
    return y;
  endfunction

  // GEMM stub: every CMD_STREAM cycle (zeros included) yields row*W after L cycles.
  always @(posedge clk) begin
    if (!resetn) vpipe <= '0;
    else begin
      if (bus.gemm_cmd == CMD_WRITE_WEIGHTS) sw <= bus.gemm_weight_inputs;
      vpipe <= {vpipe[L-2:0], bus.gemm_cmd == CMD_STREAM && !stub_mute};
      dpipe <= {dpipe[L-2:0], mac(bus.gemm_activation_inputs, sw)};
    end
  end
  assign bus.gemm_output_valid = vpipe[L-1];
  assign bus.gemm_activation_outputs = dpipe[L-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input row_t d, input logic last);
    exp_q.push_back({d, last});
  endtask

  task automatic mon();
    exp_t e;
    if (!resetn) begin
      done_due = 1'b0;
      prev_ww = 1'b0;
      return;
    end
    if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got data %0h last %b, expected no result", bus.res_data, bus.res_last);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", bus.res_data, e.d);
        chk("res_last", bus.res_last, e.last);
      end
    end
    if (done_due) chk("done_after_last", bus.job_done, 1);
    if (prev_ww) chk("stream_after_weights", bus.gemm_cmd, CMD_STREAM);
    done_due = bus.res_valid && bus.res_last;
    prev_ww = bus.gemm_cmd == CMD_WRITE_WEIGHTS;
    if (prev_ww) begin
      ww_cnt++;
      sidx = 0;
    end
    if (bus.gemm_cmd == CMD_STREAM) begin
      if (sidx < 2) slog[sidx] = bus.gemm_activation_inputs;
      sidx++;
    end
    if (bus.gemm_cmd != CMD_NONE) cmd_cycles++;
    if (bus.job_done) done_cnt++;
    if (bus.job_error) err_cnt++;
  endtask

  task automatic start_job(input mat_t w, input int n);
    bus.job_start = 1'b1;
    bus.job_num_rows = 3'(n);
    bus.job_weights = w;
    @(negedge clk);
    bus.job_start = 1'b0;
  endtask

  task automatic send_row(input row_t r, input int gap);
    int n = 0;
    while (!bus.act_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.act_ready) chk("act_ready_timeout", bus.act_ready, 1);
    bus.act_valid = 1'b1;
    bus.act_data = r;
    @(negedge clk);
    bus.act_valid = 1'b0;
    bus.act_data = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.job_busy && n < 300) begin @(negedge clk); n++; end
    chk(name, bus.job_busy, 0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(bus.gemm_cmd == CMD_STREAM && bus.gemm_activation_inputs == '0) && n < 50) begin @(negedge clk); n++; end
    chk(name, bus.gemm_cmd == CMD_STREAM && bus.gemm_activation_inputs == '0, 1);
  endtask

  task automatic job_w1(input int gap, input string tag);
    ww0 = ww_cnt;
    dn0 = done_cnt;
    push(rw(7, 4), 1'b0);
    push(rw(23, 16), 1'b1);
    start_job(w1, 2);
    send_row(rw(1, 2), gap);
    send_row(rw(5, 6), 0);
    chk({tag, "_ready_drop"}, bus.act_ready, 0);
    wait_idle({tag, "_idle"});
    chk({tag, "_ww_once"}, ww_cnt - ww0, 1);
    chk({tag, "_done_once"}, done_cnt - dn0, 1);
    chk({tag, "_stream_row0"}, slog[0], rw(1, 2));
    chk({tag, "_stream_row1"}, slog[1], rw(5, 6));
    chk({tag, "_all_results"}, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bus.job_start = 1'b0;
    bus.job_num_rows = '0;
    bus.job_weights = '0;
    bus.act_valid = 1'b0;
    bus.act_data = '0;
    w1 = mt(rw(1, 2), rw(3, 1));
    wid = mt(rw(1, 0), rw(0, 1));
    fork
      forever begin @(negedge clk); mon(); end
    join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.job_busy, 0);
    chk("rst_ready", bus.act_ready, 0);
    chk("rst_cmd", bus.gemm_cmd, CMD_NONE);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_weights", bus.gemm_weight_inputs, 0);
    resetn = 1'b1;
    @(negedge clk);
    job_w1(0, "t1");
    repeat (3) @(negedge clk);
    job_w1(2, "t2");
    repeat (3) @(negedge clk);
    c0 = cmd_cycles;
    dn0 = done_cnt;
    start_job(w1, 0);
    chk("t3_done_pulse", bus.job_done, 1);
    chk("t3_not_busy", bus.job_busy, 0);
    repeat (5) @(negedge clk);
    chk("t3_no_cmd", cmd_cycles - c0, 0);
    chk("t3_done_once", done_cnt - dn0, 1);
    ww0 = ww_cnt;
    push(rw(7, 4), 1'b0);
    push(rw(23, 16), 1'b1);
    start_job(w1, 2);
    send_row(rw(1, 2), 0);
    send_row(rw(5, 6), 0);
    t = 0;
    while (bus.gemm_cmd != CMD_STREAM && t < 20) begin @(negedge clk); t++; end
    start_job(wid, 1);
    busy_low = 0;
    t = 0;
    while (!bus.job_done && t < 100) begin
      if (!bus.job_busy) busy_low++;
      @(negedge clk);
      t++;
    end
    chk("t4_done_seen", bus.job_done, 1);
    chk("t4_busy_held", busy_low, 0);
    chk("t4_busy_in_done", bus.job_busy, 1);
    repeat (8) @(negedge clk);
    chk("t4_idle", bus.job_busy, 0);
    chk("t4_weights_kept", bus.gemm_weight_inputs, w1);
    chk("t4_ww_once", ww_cnt - ww0, 1);
    chk("t4_all_results", exp_q.size(), 0);
    stub_mute = 1'b1;
    dn0 = done_cnt;
    start_job(w1, 2);
    send_row(rw(1, 2), 0);
    send_row(rw(5, 6), 0);
    wait_drain("t5_in_drain");
    resetn = 1'b0;
    @(negedge clk);
    chk("t5_busy", bus.job_busy, 0);
    chk("t5_ready", bus.act_ready, 0);
    chk("t5_done", bus.job_done, 0);
    chk("t5_res_valid", bus.res_valid, 0);
    chk("t5_res_last", bus.res_last, 0);
    chk("t5_res_data", bus.res_data, 0);
    chk("t5_cmd", bus.gemm_cmd, CMD_NONE);
    chk("t5_weights", bus.gemm_weight_inputs, 0);
    resetn = 1'b1;
    stub_mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt - dn0, 0);
    push(rw(9, 4), 1'b1);
    start_job(wid, 1);
    send_row(rw(9, 4), 0);
    wait_idle("t5_idle");
    chk("t5_all_results", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    push(rw(1, 2), 1'b0);
    push(rw(3, 1), 1'b0);
    push(rw(4, 3), 1'b0);
    push(rw(11, 7), 1'b1);
    start_job(w1, 5);
    send_row(rw(1, 0), 0);
    send_row(rw(0, 1), 1);
    send_row(rw(1, 1), 0);
    send_row(rw(2, 3), 0);
    chk("t6_ready_drop", bus.act_ready, 0);
    wait_idle("t6_idle");
    chk("t6_all_results", exp_q.size(), 0);
`ifdef GEMM_SEQ_TIMEOUT_EN
    repeat (3) @(negedge clk);
    stub_mute = 1'b1;
    dn0 = done_cnt;
    start_job(w1, 1);
    send_row(rw(1, 2), 0);
    wait_drain("t7_in_drain");
    k = 0;
    while (!bus.job_error && k < 200) begin @(negedge clk); k++; end
    chk("t7_timeout_cycles", k, 64);
    chk("t7_busy", bus.job_busy, 0);
    chk("t7_cmd", bus.gemm_cmd, CMD_NONE);
    @(negedge clk);
    chk("t7_error_pulse", bus.job_error, 0);
    chk("t7_no_done", done_cnt - dn0, 0);
    stub_mute = 1'b0;
    chk("error_pulses", err_cnt, 1);
`else
    chk("error_pulses", err_cnt, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
